// File: rtl/ixc_assign_pkg.sv
// Shared defaults and debug-register reset constants for the ixc_assign cell family.
package ixc_assign_pkg;

  localparam int   IXC_ASSIGN_W_DEFAULT = 1;

  localparam logic FORCED_RST           = 1'b0;
  localparam logic CHG_RST              = 1'b0;
  localparam logic FORCE_REG_RST_BIT    = 1'b0;
  localparam logic SNAP_RST_BIT         = 1'b0;

endpackage

// File: rtl/ixc_assign_snap.sv
// Per-cycle source snapshot and sticky change detector of the ixc_assign debug shell.
// Registers exist only when IXC_ASSIGN_DEBUG_EN is defined; otherwise outputs are tied to 0.
module ixc_assign_snap
  import ixc_assign_pkg::*;
#(
  parameter int W = IXC_ASSIGN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src,
  input  logic         clr_chg,
  output logic [W-1:0] snap,
  output logic         chg
);

`ifdef IXC_ASSIGN_DEBUG_EN
  logic [W-1:0] snap_d, snap_q;
  logic         chg_d, chg_q;

  // Case inequality so that X/Z on the source registers as a change; a change beats a clear.
  always_comb begin
    snap_d = src;
    chg_d  = chg_q;
    if (clr_chg) begin
      chg_d = 1'b0;
    end
    if (src !== snap_q) begin
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= {W{SNAP_RST_BIT}};
      chg_q  <= CHG_RST;
    end else begin
      snap_q <= snap_d;
      chg_q  <= chg_d;
    end
  end

  assign snap = snap_q;
  assign chg  = chg_q;
`else
  logic unused_snap_in;

  assign unused_snap_in = ^{clk, rst, src, clr_chg};
  assign snap           = '0;
  assign chg            = 1'b0;
`endif

endmodule

// File: rtl/ixc_assign_buf.sv
// Zero-latency connection cell (dst driven from src) with an optional clocked debug shell:
// force override, source snapshot and sticky change flag, built only with IXC_ASSIGN_DEBUG_EN.
module ixc_assign_buf
  import ixc_assign_pkg::*;
#(
  parameter int W = IXC_ASSIGN_W_DEFAULT
) (
  output logic [W-1:0] dst,
  input  logic [W-1:0] src,
  input  logic         clk       = 1'b0,
  input  logic         rst       = 1'b0,
  input  logic         force_set = 1'b0,
  input  logic         force_clr = 1'b0,
  input  logic [W-1:0] force_val = '0,
  input  logic         clr_chg   = 1'b0,
  output logic         forced,
  output logic [W-1:0] snap,
  output logic         chg
);

  ixc_assign_snap #(
    .W (W)
  ) u_snap (
    .clk     (clk),
    .rst     (rst),
    .src     (src),
    .clr_chg (clr_chg),
    .snap    (snap),
    .chg     (chg)
  );

`ifdef IXC_ASSIGN_DEBUG_EN
  logic         forced_d, forced_q;
  logic [W-1:0] force_reg_d, force_reg_q;

  // Set has priority over clear and always reloads the override value.
  always_comb begin
    forced_d    = forced_q;
    force_reg_d = force_reg_q;
    if (force_set) begin
      forced_d    = 1'b1;
      force_reg_d = force_val;
    end else if (force_clr) begin
      forced_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      forced_q    <= FORCED_RST;
      force_reg_q <= {W{FORCE_REG_RST_BIT}};
    end else begin
      forced_q    <= forced_d;
      force_reg_q <= force_reg_d;
    end
  end

  assign dst    = forced_q ? force_reg_q : src;
  assign forced = forced_q;
`else
  logic unused_force_in;

  assign unused_force_in = ^{force_set, force_clr, force_val};
  assign dst             = src;
  assign forced          = 1'b0;
`endif

endmodule

// File: tb/tb_ixc_assign_buf.sv
// Self-checking bench for ixc_assign_buf: scoreboard of expected outputs per clock edge,
// valid with or without IXC_ASSIGN_DEBUG_EN defined.
module tb_ixc_assign_buf;

`ifdef IXC_ASSIGN_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  typedef struct {
    logic       r;
    logic       s;
    logic       c;
    logic [7:0] fv;
    logic       cc;
    logic [7:0] sv;
  } stim_t;

  typedef struct {
    string      tag;
    logic [7:0] dst;
    logic       forced;
    logic [7:0] snap;
    logic       chg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src, dst, force_val, snap;
  logic        force_set, force_clr, clr_chg, forced, chg;

  logic [70:0] wide_src, wide_dst, wide_snap;
  logic        wide_forced, wide_chg;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  logic        m_forced = 1'b0;
  logic [7:0]  m_freg   = 8'h00;
  logic [7:0]  m_snap   = 8'h00;
  logic        m_chg    = 1'b0;

  always #5 clk = ~clk;

  ixc_assign_buf #(8) dut (
    .dst       (dst),
    .src       (src),
    .clk       (clk),
    .rst       (rst),
    .force_set (force_set),
    .force_clr (force_clr),
    .force_val (force_val),
    .clr_chg   (clr_chg),
    .forced    (forced),
    .snap      (snap),
    .chg       (chg)
  );

  // Wide cell wired like a two-port instance: debug inputs at 0, shell held in reset.
  ixc_assign_buf #(71) dut_wide (
    .dst       (wide_dst),
    .src       (wide_src),
    .clk       (clk),
    .rst       (1'b1),
    .force_set (1'b0),
    .force_clr (1'b0),
    .force_val (71'd0),
    .clr_chg   (1'b0),
    .forced    (wide_forced),
    .snap      (wide_snap),
    .chg       (wide_chg)
  );

  // Applies one cycle of stimulus, advances the reference model, queues the expectation.
  task automatic drive(input string tag, input stim_t st);
    exp_t e;
    rst       = st.r;
    force_set = st.s;
    force_clr = st.c;
    force_val = st.fv;
    clr_chg   = st.cc;
    src       = st.sv;
    if (DBG) begin
      if (st.r) begin
        m_forced = 1'b0;
        m_freg   = 8'h00;
        m_snap   = 8'h00;
        m_chg    = 1'b0;
      end else begin
        if (st.s) begin
          m_forced = 1'b1;
          m_freg   = st.fv;
        end else if (st.c) begin
          m_forced = 1'b0;
        end
        if (st.sv !== m_snap) m_chg = 1'b1;
        else if (st.cc) m_chg = 1'b0;
        m_snap = st.sv;
      end
    end
    e.tag    = tag;
    e.dst    = m_forced ? m_freg : st.sv;
    e.forced = m_forced;
    e.snap   = m_snap;
    e.chg    = m_chg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    force_set = 1'b0;
    force_clr = 1'b0;
    clr_chg   = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    drive("reset", '{r:1, s:1, c:0, fv:8'hEE, cc:1, sv:8'h5A});
    e = sb.pop_front();
    checks += 4;
    if (dst !== e.dst) begin errors++; $display("[TB] FAIL %s dst got %h want %h", e.tag, dst, e.dst); end
    if (forced !== 1'b0) begin errors++; $display("[TB] FAIL %s forced got %b want 0", e.tag, forced); end
    if (snap !== 8'h00) begin errors++; $display("[TB] FAIL %s snap got %h want 00", e.tag, snap); end
    if (chg !== 1'b0) begin errors++; $display("[TB] FAIL %s chg got %b want 0", e.tag, chg); end
  endtask

  task automatic test_passthrough();
    logic [70:0] pats [3];
    logic [7:0]  sv;
    pats[0] = 71'd0;
    pats[1] = {1'b1, {35{2'b01}}};
    pats[2] = {71{1'b1}};
    for (int i = 0; i < 3; i++) begin
      wide_src = pats[i];
      #1;
      checks += 4;
      if (wide_dst !== pats[i]) begin errors++; $display("[TB] FAIL wide_pass dst got %h want %h", wide_dst, pats[i]); end
      if (wide_forced !== 1'b0) begin errors++; $display("[TB] FAIL wide_pass forced got %b want 0", wide_forced); end
      if (wide_snap !== 71'd0) begin errors++; $display("[TB] FAIL wide_pass snap got %h want 0", wide_snap); end
      if (wide_chg !== 1'b0) begin errors++; $display("[TB] FAIL wide_pass chg got %b want 0", wide_chg); end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      sv  = 8'(i * 8'h47 + 8'h13);
      src = sv;
      #1;
      checks++;
      if (dst !== sv) begin errors++; $display("[TB] FAIL comb_pass dst got %h want %h", dst, sv); end
    end
    @(posedge clk);
    #1;
    m_chg  = DBG ? (m_chg || (src !== m_snap)) : 1'b0;
    m_snap = DBG ? src : 8'h00;
  endtask

  task automatic test_force();
    exp_t  e;
    stim_t st;
    for (int i = 0; i < 6; i++) begin
      st = '{r:0, s:(i == 0), c:(i == 4), fv:8'hA5, cc:0, sv:8'h3C};
      drive($sformatf("force_c%0d", i), st);
      e = sb.pop_front();
      checks += 4;
      if (dst !== e.dst) begin errors++; $display("[TB] FAIL %s dst got %h want %h", e.tag, dst, e.dst); end
      if (forced !== e.forced) begin errors++; $display("[TB] FAIL %s forced got %b want %b", e.tag, forced, e.forced); end
      if (snap !== e.snap) begin errors++; $display("[TB] FAIL %s snap got %h want %h", e.tag, snap, e.snap); end
      if (chg !== e.chg) begin errors++; $display("[TB] FAIL %s chg got %b want %b", e.tag, chg, e.chg); end
      if (i == 0) begin
        checks++;
        if (dst !== (DBG ? 8'hA5 : 8'h3C)) begin errors++; $display("[TB] FAIL force_set_val dst got %h want %h", dst, DBG ? 8'hA5 : 8'h3C); end
      end
      if (i == 4) begin
        checks++;
        if (dst !== 8'h3C) begin errors++; $display("[TB] FAIL force_release dst got %h want 3c", dst); end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    drive("set_and_clr", '{r:0, s:1, c:1, fv:8'h0F, cc:0, sv:8'h3C});
    e = sb.pop_front();
    checks += 3;
    if (dst !== e.dst) begin errors++; $display("[TB] FAIL %s dst got %h want %h", e.tag, dst, e.dst); end
    if (forced !== e.forced) begin errors++; $display("[TB] FAIL %s forced got %b want %b", e.tag, forced, e.forced); end
    if (dst !== (DBG ? 8'h0F : 8'h3C)) begin errors++; $display("[TB] FAIL set_wins dst got %h want %h", dst, DBG ? 8'h0F : 8'h3C); end
    drive("release", '{r:0, s:0, c:1, fv:8'h00, cc:0, sv:8'h3C});
    e = sb.pop_front();
    checks++;
    if (forced !== 1'b0) begin errors++; $display("[TB] FAIL %s forced got %b want 0", e.tag, forced); end
  endtask

  task automatic test_change_flag();
    exp_t e;
    drive("chg_reset", '{r:1, s:0, c:0, fv:8'h00, cc:0, sv:8'h00});
    void'(sb.pop_front());
    for (int i = 0; i < 12; i++) begin
      drive($sformatf("chg_c%0d", i), '{r:0, s:0, c:0, fv:8'h00, cc:(i == 8), sv:(i >= 3) ? 8'h01 : 8'h00});
      e = sb.pop_front();
      checks += 3;
      if (snap !== e.snap) begin errors++; $display("[TB] FAIL %s snap got %h want %h", e.tag, snap, e.snap); end
      if (chg !== e.chg) begin errors++; $display("[TB] FAIL %s chg got %b want %b", e.tag, chg, e.chg); end
      if (dst !== e.dst) begin errors++; $display("[TB] FAIL %s dst got %h want %h", e.tag, dst, e.dst); end
      if (i == 5) begin
        checks += 2;
        if (chg !== DBG) begin errors++; $display("[TB] FAIL chg_sticky chg got %b want %b", chg, DBG); end
        if (snap !== (DBG ? 8'h01 : 8'h00)) begin errors++; $display("[TB] FAIL snap_value snap got %h want %h", snap, DBG ? 8'h01 : 8'h00); end
      end
      if (i == 10) begin
        checks++;
        if (chg !== 1'b0) begin errors++; $display("[TB] FAIL chg_cleared chg got %b want 0", chg); end
      end
    end
  endtask

  task automatic test_reset_mid_force();
    exp_t e;
    drive("force_ff", '{r:0, s:1, c:0, fv:8'hFF, cc:0, sv:8'h21});
    void'(sb.pop_front());
    drive("mid_reset", '{r:1, s:1, c:0, fv:8'hAA, cc:1, sv:8'h77});
    e = sb.pop_front();
    checks += 4;
    if (forced !== 1'b0) begin errors++; $display("[TB] FAIL %s forced got %b want 0", e.tag, forced); end
    if (dst !== 8'h77) begin errors++; $display("[TB] FAIL %s dst got %h want 77", e.tag, dst); end
    if (snap !== 8'h00) begin errors++; $display("[TB] FAIL %s snap got %h want 00", e.tag, snap); end
    if (chg !== 1'b0) begin errors++; $display("[TB] FAIL %s chg got %b want 0", e.tag, chg); end
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t st;
    for (int i = 0; i < 40; i++) begin
      st.r  = ($urandom_range(0, 15) == 0);
      st.s  = ($urandom_range(0, 3) == 0);
      st.c  = ($urandom_range(0, 3) == 0);
      st.fv = 8'($urandom);
      st.cc = ($urandom_range(0, 2) == 0);
      st.sv = ($urandom_range(0, 1) == 0) ? src : 8'($urandom);
      drive($sformatf("b2b_%0d", i), st);
      e = sb.pop_front();
      checks += 4;
      if (dst !== e.dst) begin errors++; $display("[TB] FAIL %s dst got %h want %h", e.tag, dst, e.dst); end
      if (forced !== e.forced) begin errors++; $display("[TB] FAIL %s forced got %b want %b", e.tag, forced, e.forced); end
      if (snap !== e.snap) begin errors++; $display("[TB] FAIL %s snap got %h want %h", e.tag, snap, e.snap); end
      if (chg !== e.chg) begin errors++; $display("[TB] FAIL %s chg got %b want %b", e.tag, chg, e.chg); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    src       = 8'h00;
    force_set = 1'b0;
    force_clr = 1'b0;
    force_val = 8'h00;
    clr_chg   = 1'b0;
    wide_src  = 71'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_force();
    test_simultaneous();
    test_change_flag();
    test_reset_mid_force();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
